// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared FSM encoding, field widths and counter sizing for the
//               instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam logic [1:0] c_WAIT_HI = 2'd0;
    localparam logic [1:0] c_WAIT_LO = 2'd1;
    localparam logic [1:0] c_PUBLISH = 2'd2;

    localparam int c_OPCODE_W = 4;
    localparam int c_INSTR_W  = 12;

    // A one-bit counter is kept even for degenerate parameter values.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes a bouncy push-button and emits a one-cycle pulse
//               on each accepted rising edge of the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import instr_loader_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_edge
);

    localparam int                c_CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            btn_edge <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            btn_edge <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                // Level accepted after holding DEBOUNCE_CYCLES cycles; pulse only on press.
                r_level  <= w_sync;
                r_cnt    <= '0;
                btn_edge <= w_sync;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Builds a 16-bit instruction from two debounced switch-byte
//               loads and publishes it atomically with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            sw_in,
    input  logic                  btn_raw,
    output logic [c_OPCODE_W-1:0] opcode,
    output logic [c_INSTR_W-1:0]  instr,
    output logic                  inst_done,
    output logic                  btn_edge,
    output logic                  byte_phase
);

    logic [SYNC_STAGES-1:0][7:0] r_sw_sync;
    logic [7:0]                  w_sw;
    logic [7:0]                  r_shadow;
    logic [1:0]                  r_state;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_edge (btn_edge)
    );

    assign w_sw       = r_sw_sync[SYNC_STAGES-1];
    assign byte_phase = (r_state == c_WAIT_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_sync <= '0;
            r_shadow  <= '0;
            r_state   <= c_WAIT_HI;
            opcode    <= '0;
            instr     <= '0;
            inst_done <= 1'b0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw_in};
            inst_done <= 1'b0;
            case (r_state)
                c_WAIT_HI: begin
                    if (btn_edge) begin
                        r_shadow <= w_sw;
                        r_state  <= c_WAIT_LO;
                    end
                end
                c_WAIT_LO: begin
                    // Both halves land in one edge so the core never sees a torn word.
                    if (btn_edge) begin
                        opcode    <= r_shadow[7:4];
                        instr     <= {r_shadow[3:0], w_sw};
                        inst_done <= 1'b1;
                        r_state   <= c_PUBLISH;
                    end
                end
                c_PUBLISH: r_state <= c_WAIT_HI;
                default:   r_state <= c_WAIT_HI;
            endcase
        end
    end

    a_no_edge_in_publish : assert property (@(posedge clk) disable iff (rst)
        !((r_state == c_PUBLISH) && btn_edge));

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Directed self-checking bench for instr_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  sw_in;
    logic        btn_raw;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic        byte_phase;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int done_cnt = 0;
    int lat;
    int e0;

    instr_loader #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .btn_raw    (btn_raw),
        .opcode     (opcode),
        .instr      (instr),
        .inst_done  (inst_done),
        .btn_edge   (btn_edge),
        .byte_phase (byte_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (btn_edge === 1'b1) edge_cnt <= edge_cnt + 1;
        if (inst_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the btn_edge cycle, lat = cycles from press.
    task automatic press(input logic [7:0] val, output int n);
        sw_in   = val;
        btn_raw = 1'b1;
        n = 0;
        while (btn_edge !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("edge_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic release_btn();
        btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; sw_in = 8'h00; btn_raw = 1'b1;

        // Reset held with the button pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs", {opcode, instr, inst_done, btn_edge, byte_phase}, 32'd0);
        end
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_edge_early", 32'(btn_edge), 32'd0);
        tick();
        chk("rst_edge_latency", 32'(btn_edge), 32'd1);
        tick();
        chk("rst_edge_width", 32'(btn_edge), 32'd0);
        chk("rst_byte_phase", 32'(byte_phase), 32'd1);
        release_btn();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        chk("rst_phase_clear", 32'(byte_phase), 32'd0);

        // Clean load A5 / 3C
        press(8'hA5, lat);
        chk("load_latency", 32'(lat), 32'd6);
        tick();
        chk("load_phase_hi", 32'(byte_phase), 32'd1);
        release_btn();
        press(8'h3C, lat);
        chk("load_done_early", 32'(inst_done), 32'd0);
        tick();
        chk("load_done", 32'(inst_done), 32'd1);
        chk("load_opcode", 32'(opcode), 32'hA);
        chk("load_instr", 32'(instr), 32'h53C);
        tick();
        chk("load_done_width", 32'(inst_done), 32'd0);
        chk("load_phase_lo", 32'(byte_phase), 32'd0);
        release_btn();

        // Switch sampling: sw changes one cycle after the high-byte edge
        press(8'h12, lat);
        tick();
        sw_in = 8'hFF;
        release_btn();
        press(8'h34, lat);
        tick();
        chk("sample_opcode", 32'(opcode), 32'h1);
        chk("sample_instr", 32'(instr), 32'h234);
        release_btn();

        // Atomicity: high-byte load does not disturb published word
        press(8'hFF, lat);
        tick();
        chk("atom_opcode", 32'(opcode), 32'h1);
        chk("atom_instr", 32'(instr), 32'h234);
        release_btn();
        chk("atom_opcode_hold", 32'(opcode), 32'h1);
        chk("atom_instr_hold", 32'(instr), 32'h234);
        press(8'h00, lat);
        tick();
        chk("atom_pub_opcode", 32'(opcode), 32'hF);
        chk("atom_pub_instr", 32'(instr), 32'hF00);
        release_btn();

        // Bounce rejection then a steady hold
        e0 = edge_cnt;
        sw_in = 8'h56;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            tick(); tick();
        end
        chk("bounce_no_edge", 32'(edge_cnt - e0), 32'd0);
        press(8'h56, lat);
        tick();
        release_btn();
        btn_raw = 1'b1;
        repeat (3) tick();
        release_btn();
        chk("bounce_one_edge", 32'(edge_cnt - e0), 32'd1);
        chk("bounce_phase", 32'(byte_phase), 32'd1);
        press(8'h78, lat);
        tick();
        chk("bounce_opcode", 32'(opcode), 32'h5);
        chk("bounce_instr", 32'(instr), 32'h678);
        release_btn();

        // Mid-load reset discards the shadow byte
        press(8'h77, lat);
        tick();
        release_btn();
        rst = 1'b1; tick(); tick();
        chk("midrst_outputs", {opcode, instr, inst_done, byte_phase}, 32'd0);
        rst = 1'b0; tick();
        press(8'h12, lat);
        tick();
        release_btn();
        press(8'h34, lat);
        tick();
        chk("midrst_opcode", 32'(opcode), 32'h1);
        chk("midrst_instr", 32'(instr), 32'h234);
        release_btn();

        chk("done_pulse_total", 32'(done_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
